// File: rtl/alu_rs_scheduler.sv
// ----------------------------------------------------------------------------
// alu_rs_scheduler
// Reservation station sitting in front of the single shared ALU. It holds
// dispatched ALU/branch micro-ops until both operands are known, snoops the
// ALU and load/store CDBs for operand wakeup (including same-cycle bypass at
// dispatch) and issues the lowest-index ready entry each cycle onto registered
// ALU inputs. issue_op == 0 tells the ALU that nothing was issued.
// ----------------------------------------------------------------------------
module alu_rs_scheduler #(
    parameter int RS_SIZE = 8,
    parameter int ROB_W   = 4,
    parameter int OP_W    = 6
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear_in,

    input  logic              disp_valid,
    input  logic [OP_W-1:0]   disp_op,
    input  logic [31:0]       disp_vj,
    input  logic [31:0]       disp_vk,
    input  logic              disp_qj_busy,
    input  logic              disp_qk_busy,
    input  logic [ROB_W-1:0]  disp_qj,
    input  logic [ROB_W-1:0]  disp_qk,
    input  logic [ROB_W-1:0]  disp_robid,
    output logic              rs_full,

    input  logic              cdb_alu_valid,
    input  logic [ROB_W-1:0]  cdb_alu_robid,
    input  logic [31:0]       cdb_alu_result,
    input  logic              cdb_lsb_valid,
    input  logic [ROB_W-1:0]  cdb_lsb_robid,
    input  logic [31:0]       cdb_lsb_result,

    output logic [OP_W-1:0]   issue_op,
    output logic [31:0]       issue_rs1,
    output logic [31:0]       issue_rs2,
    output logic [ROB_W-1:0]  issue_robid
);

    // Constant one used by the lowest-set-bit / lowest-clear-bit tricks.
    localparam logic [RS_SIZE-1:0] ONE_V = {{(RS_SIZE-1){1'b0}}, 1'b1};

    // True when a valid CDB broadcast carries the tag being waited on.
    function automatic logic cdb_hit(
        input logic             valid,
        input logic [ROB_W-1:0] cdb_robid,
        input logic [ROB_W-1:0] tag
    );
        return valid && (cdb_robid == tag);
    endfunction

    // Resolve one operand against both CDBs; returns {still_pending, value}.
    // The ALU bus wins when both buses carry the same tag.
    function automatic logic [32:0] resolve_operand(
        input logic             pending,
        input logic [ROB_W-1:0] tag,
        input logic [31:0]      value,
        input logic             alu_valid,
        input logic [ROB_W-1:0] alu_robid,
        input logic [31:0]      alu_result,
        input logic             lsb_valid,
        input logic [ROB_W-1:0] lsb_robid,
        input logic [31:0]      lsb_result
    );
        logic [32:0] res;
        if (!pending) begin
            res = {1'b0, value};
        end else if (cdb_hit(alu_valid, alu_robid, tag)) begin
            res = {1'b0, alu_result};
        end else if (cdb_hit(lsb_valid, lsb_robid, tag)) begin
            res = {1'b0, lsb_result};
        end else begin
            res = {1'b1, value};
        end
        return res;
    endfunction

    // Entry storage
    logic [RS_SIZE-1:0] busy_q,     busy_d;
    logic [RS_SIZE-1:0] qj_busy_q,  qj_busy_d;
    logic [RS_SIZE-1:0] qk_busy_q,  qk_busy_d;
    logic [OP_W-1:0]    op_q    [RS_SIZE];
    logic [OP_W-1:0]    op_d    [RS_SIZE];
    logic [31:0]        vj_q    [RS_SIZE];
    logic [31:0]        vj_d    [RS_SIZE];
    logic [31:0]        vk_q    [RS_SIZE];
    logic [31:0]        vk_d    [RS_SIZE];
    logic [ROB_W-1:0]   qj_q    [RS_SIZE];
    logic [ROB_W-1:0]   qj_d    [RS_SIZE];
    logic [ROB_W-1:0]   qk_q    [RS_SIZE];
    logic [ROB_W-1:0]   qk_d    [RS_SIZE];
    logic [ROB_W-1:0]   robid_q [RS_SIZE];
    logic [ROB_W-1:0]   robid_d [RS_SIZE];

    // Registered outputs
    logic               rs_full_q,     rs_full_d;
    logic [OP_W-1:0]    issue_op_q,    issue_op_d;
    logic [31:0]        issue_rs1_q,   issue_rs1_d;
    logic [31:0]        issue_rs2_q,   issue_rs2_d;
    logic [ROB_W-1:0]   issue_robid_q, issue_robid_d;

    // Selection / wakeup helpers
    logic [RS_SIZE-1:0] ready_s;
    logic [RS_SIZE-1:0] sel_oh_s;
    logic [RS_SIZE-1:0] free_oh_s;
    logic               disp_fire_s;
    logic [OP_W-1:0]    sel_op_s;
    logic [31:0]        sel_vj_s;
    logic [31:0]        sel_vk_s;
    logic [ROB_W-1:0]   sel_robid_s;
    logic [32:0]        disp_j_s;
    logic [32:0]        disp_k_s;
    logic [32:0]        wake_j_s [RS_SIZE];
    logic [32:0]        wake_k_s [RS_SIZE];

    // Pick issue candidate and free slot from start-of-cycle state; resolve operands.
    always_comb begin
        ready_s     = busy_q & ~qj_busy_q & ~qk_busy_q;
        sel_oh_s    = ready_s & (~ready_s + ONE_V);
        free_oh_s   = ~busy_q & (busy_q + ONE_V);
        disp_fire_s = disp_valid & ~rs_full_q;

        sel_op_s    = {OP_W{1'b0}};
        sel_vj_s    = 32'd0;
        sel_vk_s    = 32'd0;
        sel_robid_s = {ROB_W{1'b0}};
        for (int i = 0; i < RS_SIZE; i++) begin
            sel_op_s    = sel_op_s    | (sel_oh_s[i] ? op_q[i]    : {OP_W{1'b0}});
            sel_vj_s    = sel_vj_s    | (sel_oh_s[i] ? vj_q[i]    : 32'd0);
            sel_vk_s    = sel_vk_s    | (sel_oh_s[i] ? vk_q[i]    : 32'd0);
            sel_robid_s = sel_robid_s | (sel_oh_s[i] ? robid_q[i] : {ROB_W{1'b0}});
            wake_j_s[i] = resolve_operand(qj_busy_q[i], qj_q[i], vj_q[i],
                                          cdb_alu_valid, cdb_alu_robid, cdb_alu_result,
                                          cdb_lsb_valid, cdb_lsb_robid, cdb_lsb_result);
            wake_k_s[i] = resolve_operand(qk_busy_q[i], qk_q[i], vk_q[i],
                                          cdb_alu_valid, cdb_alu_robid, cdb_alu_result,
                                          cdb_lsb_valid, cdb_lsb_robid, cdb_lsb_result);
        end

        disp_j_s = resolve_operand(disp_qj_busy, disp_qj, disp_vj,
                                   cdb_alu_valid, cdb_alu_robid, cdb_alu_result,
                                   cdb_lsb_valid, cdb_lsb_robid, cdb_lsb_result);
        disp_k_s = resolve_operand(disp_qk_busy, disp_qk, disp_vk,
                                   cdb_alu_valid, cdb_alu_robid, cdb_alu_result,
                                   cdb_lsb_valid, cdb_lsb_robid, cdb_lsb_result);
    end

    // Next state: clear beats stall beats normal dispatch/wakeup/issue.
    always_comb begin
        busy_d        = busy_q;
        qj_busy_d     = qj_busy_q;
        qk_busy_d     = qk_busy_q;
        op_d          = op_q;
        vj_d          = vj_q;
        vk_d          = vk_q;
        qj_d          = qj_q;
        qk_d          = qk_q;
        robid_d       = robid_q;
        rs_full_d     = rs_full_q;
        issue_op_d    = issue_op_q;
        issue_rs1_d   = issue_rs1_q;
        issue_rs2_d   = issue_rs2_q;
        issue_robid_d = issue_robid_q;

        if (clear_in) begin
            busy_d     = {RS_SIZE{1'b0}};
            issue_op_d = {OP_W{1'b0}};
            rs_full_d  = 1'b0;
        end else if (!rdy_in) begin
            issue_op_d = {OP_W{1'b0}};
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (disp_fire_s && free_oh_s[i]) begin
                    // Only a non-busy slot is chosen, so it cannot also be issuing.
                    busy_d[i]              = 1'b1;
                    op_d[i]                = disp_op;
                    {qj_busy_d[i], vj_d[i]} = disp_j_s;
                    {qk_busy_d[i], vk_d[i]} = disp_k_s;
                    qj_d[i]                = disp_qj;
                    qk_d[i]                = disp_qk;
                    robid_d[i]             = disp_robid;
                end else if (busy_q[i]) begin
                    {qj_busy_d[i], vj_d[i]} = wake_j_s[i];
                    {qk_busy_d[i], vk_d[i]} = wake_k_s[i];
                    busy_d[i]              = ~sel_oh_s[i];
                end else begin
                    busy_d[i] = 1'b0;
                end
            end

            if (|ready_s) begin
                issue_op_d    = sel_op_s;
                issue_rs1_d   = sel_vj_s;
                issue_rs2_d   = sel_vk_s;
                issue_robid_d = sel_robid_s;
            end else begin
                issue_op_d = {OP_W{1'b0}};
            end

            rs_full_d = &busy_d;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q        <= {RS_SIZE{1'b0}};
            qj_busy_q     <= {RS_SIZE{1'b0}};
            qk_busy_q     <= {RS_SIZE{1'b0}};
            for (int i = 0; i < RS_SIZE; i++) begin
                op_q[i]    <= {OP_W{1'b0}};
                vj_q[i]    <= 32'd0;
                vk_q[i]    <= 32'd0;
                qj_q[i]    <= {ROB_W{1'b0}};
                qk_q[i]    <= {ROB_W{1'b0}};
                robid_q[i] <= {ROB_W{1'b0}};
            end
            rs_full_q     <= 1'b0;
            issue_op_q    <= {OP_W{1'b0}};
            issue_rs1_q   <= 32'd0;
            issue_rs2_q   <= 32'd0;
            issue_robid_q <= {ROB_W{1'b0}};
        end else begin
            busy_q        <= busy_d;
            qj_busy_q     <= qj_busy_d;
            qk_busy_q     <= qk_busy_d;
            op_q          <= op_d;
            vj_q          <= vj_d;
            vk_q          <= vk_d;
            qj_q          <= qj_d;
            qk_q          <= qk_d;
            robid_q       <= robid_d;
            rs_full_q     <= rs_full_d;
            issue_op_q    <= issue_op_d;
            issue_rs1_q   <= issue_rs1_d;
            issue_rs2_q   <= issue_rs2_d;
            issue_robid_q <= issue_robid_d;
        end
    end

    assign rs_full     = rs_full_q;
    assign issue_op    = issue_op_q;
    assign issue_rs1   = issue_rs1_q;
    assign issue_rs2   = issue_rs2_q;
    assign issue_robid = issue_robid_q;

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// ----------------------------------------------------------------------------
// tb_alu_rs_scheduler
// Directed scenarios plus a randomized run against a behavioural model of the
// reservation station (array of entries, scanned in index order each cycle).
// ----------------------------------------------------------------------------
module tb_alu_rs_scheduler;

    localparam logic [5:0] OP_ADD = 6'd1;
    localparam logic [5:0] OP_SUB = 6'd2;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_in;
    logic        disp_valid;
    logic [5:0]  disp_op;
    logic [31:0] disp_vj, disp_vk;
    logic        disp_qj_busy, disp_qk_busy;
    logic [3:0]  disp_qj, disp_qk, disp_robid;
    logic        rs_full;
    logic        cdb_alu_valid, cdb_lsb_valid;
    logic [3:0]  cdb_alu_robid, cdb_lsb_robid;
    logic [31:0] cdb_alu_result, cdb_lsb_result;
    logic [5:0]  issue_op;
    logic [31:0] issue_rs1, issue_rs2;
    logic [3:0]  issue_robid;

    int n_checks = 0;
    int n_fail   = 0;

    alu_rs_scheduler #(.RS_SIZE(8), .ROB_W(4), .OP_W(6)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .disp_valid(disp_valid), .disp_op(disp_op), .disp_vj(disp_vj), .disp_vk(disp_vk),
        .disp_qj_busy(disp_qj_busy), .disp_qk_busy(disp_qk_busy),
        .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_robid(disp_robid), .rs_full(rs_full),
        .cdb_alu_valid(cdb_alu_valid), .cdb_alu_robid(cdb_alu_robid), .cdb_alu_result(cdb_alu_result),
        .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_robid(cdb_lsb_robid), .cdb_lsb_result(cdb_lsb_result),
        .issue_op(issue_op), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_robid(issue_robid)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        busy;
        logic [5:0]  op;
        logic [31:0] vj, vk;
        logic        qjb, qkb;
        logic [3:0]  qj, qk, robid;
    } ent_t;

    ent_t        m_ent [8];
    logic [5:0]  m_op;
    logic [31:0] m_rs1, m_rs2;
    logic [3:0]  m_robid;
    logic        m_full;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_ent[i] = '0;
        m_op = 6'd0; m_rs1 = 32'd0; m_rs2 = 32'd0; m_robid = 4'd0; m_full = 1'b0;
    endfunction

    // {still_pending, value} after looking at this cycle's CDBs (ALU first)
    function automatic logic [32:0] resolve(input logic pend, input logic [3:0] tag, input logic [31:0] val);
        if (!pend) return {1'b0, val};
        if (cdb_alu_valid && cdb_alu_robid == tag) return {1'b0, cdb_alu_result};
        if (cdb_lsb_valid && cdb_lsb_robid == tag) return {1'b0, cdb_lsb_result};
        return {1'b1, val};
    endfunction

    function automatic void model_step();
        ent_t nxt [8];
        int   sel;
        int   free;
        int   cnt;
        if (clear_in) begin
            for (int i = 0; i < 8; i++) m_ent[i].busy = 1'b0;
            m_op = 6'd0; m_full = 1'b0;
            return;
        end
        if (!rdy_in) begin
            m_op = 6'd0;
            return;
        end
        sel = -1; free = -1;
        for (int i = 0; i < 8; i++) begin
            nxt[i] = m_ent[i];
            if (sel < 0 && m_ent[i].busy && !m_ent[i].qjb && !m_ent[i].qkb) sel = i;
            if (free < 0 && !m_ent[i].busy) free = i;
            if (m_ent[i].busy) begin
                {nxt[i].qjb, nxt[i].vj} = resolve(m_ent[i].qjb, m_ent[i].qj, m_ent[i].vj);
                {nxt[i].qkb, nxt[i].vk} = resolve(m_ent[i].qkb, m_ent[i].qk, m_ent[i].vk);
            end
        end
        if (sel >= 0) begin
            m_op = m_ent[sel].op; m_rs1 = m_ent[sel].vj; m_rs2 = m_ent[sel].vk; m_robid = m_ent[sel].robid;
            nxt[sel].busy = 1'b0;
        end else begin
            m_op = 6'd0;
        end
        if (disp_valid && !m_full && free >= 0) begin
            nxt[free].busy  = 1'b1;
            nxt[free].op    = disp_op;
            {nxt[free].qjb, nxt[free].vj} = resolve(disp_qj_busy, disp_qj, disp_vj);
            {nxt[free].qkb, nxt[free].vk} = resolve(disp_qk_busy, disp_qk, disp_vk);
            nxt[free].qj    = disp_qj;
            nxt[free].qk    = disp_qk;
            nxt[free].robid = disp_robid;
        end
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            m_ent[i] = nxt[i];
            if (nxt[i].busy) cnt++;
        end
        m_full = (cnt == 8);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        rdy_in = 1'b1; clear_in = 1'b0; disp_valid = 1'b0;
        disp_op = 6'd0; disp_vj = 32'd0; disp_vk = 32'd0;
        disp_qj_busy = 1'b0; disp_qk_busy = 1'b0; disp_qj = 4'd0; disp_qk = 4'd0; disp_robid = 4'd0;
        cdb_alu_valid = 1'b0; cdb_alu_robid = 4'd0; cdb_alu_result = 32'd0;
        cdb_lsb_valid = 1'b0; cdb_lsb_robid = 4'd0; cdb_lsb_result = 32'd0;
    endtask

    task automatic set_disp(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                            input logic qjb, input logic [3:0] qj, input logic qkb, input logic [3:0] qk,
                            input logic [3:0] robid);
        disp_valid = 1'b1; disp_op = op; disp_vj = vj; disp_vk = vk;
        disp_qj_busy = qjb; disp_qj = qj; disp_qk_busy = qkb; disp_qk = qk; disp_robid = robid;
    endtask

    // advance the model and the DUT by one clock edge, then settle
    task automatic tick();
        model_step();
        @(posedge clk_in);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_in = 1'b1;
        set_idle();
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        n_checks++; if (issue_op !== 6'd0) begin n_fail++; $display("FAIL reset_op: got %0h want 0", issue_op); end
        n_checks++; if (rs_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b want 0", rs_full); end
        n_checks++; if (issue_rs1 !== 32'd0 || issue_rs2 !== 32'd0 || issue_robid !== 4'd0) begin
            n_fail++; $display("FAIL reset_operands: got %0h %0h %0h want 0 0 0", issue_rs1, issue_rs2, issue_robid); end
        rst_in = 1'b0;

        // three pending entries plus one ready op that issues
        for (int i = 0; i < 3; i++) begin
            set_disp(OP_SUB, 32'd0, 32'd0, 1'b1, 4'd11, 1'b0, 4'd0, 4'(i + 1));
            tick();
        end
        set_disp(OP_ADD, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd12);
        tick();
        set_idle();
        tick();
        n_checks++; if (issue_op !== OP_ADD) begin n_fail++; $display("FAIL pre_reset_issue: got %0h want %0h", issue_op, OP_ADD); end

        // asynchronous reset between edges
        rst_in = 1'b1;
        #2;
        n_checks++; if (issue_op !== 6'd0) begin n_fail++; $display("FAIL async_reset_op: got %0h want 0", issue_op); end
        n_checks++; if (rs_full !== 1'b0) begin n_fail++; $display("FAIL async_reset_full: got %0b want 0", rs_full); end
        n_checks++; if (issue_rs1 !== 32'd0 || issue_robid !== 4'd0) begin
            n_fail++; $display("FAIL async_reset_operands: got %0h %0h want 0 0", issue_rs1, issue_robid); end
        model_reset();
        #2;
        rst_in = 1'b0;

        set_disp(OP_SUB, 32'd20, 32'd8, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4);
        tick();
        set_idle();
        cdb_alu_valid = 1'b1; cdb_alu_robid = 4'd11; cdb_alu_result = 32'd55;
        tick();
        n_checks++; if (issue_op !== OP_SUB || issue_rs1 !== 32'd20 || issue_rs2 !== 32'd8 || issue_robid !== 4'd4) begin
            n_fail++; $display("FAIL post_reset_issue: got %0h %0h %0h %0h want %0h 14 8 4", issue_op, issue_rs1, issue_rs2, issue_robid, OP_SUB); end
        set_idle();
        tick();
        n_checks++; if (issue_op !== 6'd0) begin n_fail++; $display("FAIL reset_entries_gone: got %0h want 0", issue_op); end
    endtask

    task automatic test_basic_add();
        set_disp(OP_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
        tick();
        n_checks++; if (issue_op !== 6'd0) begin n_fail++; $display("FAIL add_not_early: got %0h want 0", issue_op); end
        set_idle();
        tick();
        n_checks++; if (issue_op !== OP_ADD || issue_rs1 !== 32'd5 || issue_rs2 !== 32'd7 || issue_robid !== 4'd3) begin
            n_fail++; $display("FAIL add_issue: got %0h %0h %0h %0h want 1 5 7 3", issue_op, issue_rs1, issue_rs2, issue_robid); end
        n_checks++; if (issue_rs1 + issue_rs2 !== 32'd12) begin
            n_fail++; $display("FAIL add_result: got %0d want 12", issue_rs1 + issue_rs2); end
        tick();
        n_checks++; if (issue_op !== 6'd0 || issue_rs1 !== 32'd5) begin
            n_fail++; $display("FAIL add_idle_hold: got %0h %0h want 0 5", issue_op, issue_rs1); end
    endtask

    task automatic test_lsb_wakeup();
        set_disp(OP_SUB, 32'd0, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd5);
        tick();
        set_idle();
        cdb_alu_valid = 1'b1; cdb_alu_robid = 4'd6; cdb_alu_result = 32'd77;
        cdb_lsb_valid = 1'b1; cdb_lsb_robid = 4'd6; cdb_lsb_result = 32'd88;
        tick();
        n_checks++; if (issue_op !== 6'd0) begin n_fail++; $display("FAIL wrong_tag_wake: got %0h want 0", issue_op); end
        set_idle();
        cdb_lsb_valid = 1'b1; cdb_lsb_robid = 4'd2; cdb_lsb_result = 32'd10;
        tick();
        n_checks++; if (issue_op !== 6'd0) begin n_fail++; $display("FAIL wake_not_early: got %0h want 0", issue_op); end
        set_idle();
        tick();
        n_checks++; if (issue_op !== OP_SUB || issue_rs1 !== 32'd10 || issue_rs2 !== 32'd1 || issue_robid !== 4'd5) begin
            n_fail++; $display("FAIL lsb_wake_issue: got %0h %0h %0h %0h want 2 a 1 5", issue_op, issue_rs1, issue_rs2, issue_robid); end
    endtask

    task automatic test_bypass();
        set_disp(OP_ADD, 32'd3, 32'd0, 1'b0, 4'd0, 1'b1, 4'd4, 4'd7);
        cdb_alu_valid = 1'b1; cdb_alu_robid = 4'd4; cdb_alu_result = 32'hFFFF_FFFF;
        cdb_lsb_valid = 1'b1; cdb_lsb_robid = 4'd4; cdb_lsb_result = 32'h0000_1234;
        tick();
        set_idle();
        tick();
        n_checks++; if (issue_op !== OP_ADD || issue_rs1 !== 32'd3 || issue_rs2 !== 32'hFFFF_FFFF || issue_robid !== 4'd7) begin
            n_fail++; $display("FAIL bypass_issue: got %0h %0h %0h %0h want 1 3 ffffffff 7", issue_op, issue_rs1, issue_rs2, issue_robid); end
    endtask

    task automatic test_fill_full();
        for (int i = 0; i < 8; i++) begin
            set_disp(OP_ADD, 32'd0, 32'(i), 1'b1, 4'd9, 1'b0, 4'd0, 4'(i));
            tick();
            if (i == 6) begin
                n_checks++; if (rs_full !== 1'b0) begin n_fail++; $display("FAIL full_at_7: got %0b want 0", rs_full); end
            end
        end
        n_checks++; if (rs_full !== 1'b1) begin n_fail++; $display("FAIL full_at_8: got %0b want 1", rs_full); end
        set_disp(OP_SUB, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
        tick();
        n_checks++; if (rs_full !== 1'b1 || issue_op !== 6'd0) begin
            n_fail++; $display("FAIL ninth_dispatch: got full=%0b op=%0h want 1 0", rs_full, issue_op); end
        set_idle();
        cdb_alu_valid = 1'b1; cdb_alu_robid = 4'd9; cdb_alu_result = 32'd100;
        tick();
        n_checks++; if (issue_op !== 6'd0 || rs_full !== 1'b1) begin
            n_fail++; $display("FAIL broadcast_edge: got op=%0h full=%0b want 0 1", issue_op, rs_full); end
        set_idle();
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++; if (issue_op !== OP_ADD || issue_robid !== 4'(i) || issue_rs1 !== 32'd100 || issue_rs2 !== 32'(i) || rs_full !== 1'b0) begin
                n_fail++; $display("FAIL drain_%0d: got op=%0h robid=%0d rs1=%0d rs2=%0d full=%0b want 1 %0d 100 %0d 0",
                                   i, issue_op, issue_robid, issue_rs1, issue_rs2, rs_full, i, i); end
        end
        tick();
        n_checks++; if (issue_op !== 6'd0) begin n_fail++; $display("FAIL drain_empty: got %0h want 0", issue_op); end
    endtask

    task automatic test_clear_rdy();
        for (int i = 0; i < 4; i++) begin
            set_disp(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd10, 1'b0, 4'd0, 4'(i));
            tick();
        end
        set_disp(OP_ADD, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
        clear_in = 1'b1;
        tick();
        n_checks++; if (issue_op !== 6'd0 || rs_full !== 1'b0) begin
            n_fail++; $display("FAIL clear_edge: got op=%0h full=%0b want 0 0", issue_op, rs_full); end
        set_idle();
        cdb_alu_valid = 1'b1; cdb_alu_robid = 4'd10; cdb_alu_result = 32'd1;
        tick();
        n_checks++; if (issue_op !== 6'd0) begin n_fail++; $display("FAIL clear_dropped_dispatch: got %0h want 0", issue_op); end
        set_idle();
        tick();
        n_checks++; if (issue_op !== 6'd0) begin n_fail++; $display("FAIL clear_entries_gone: got %0h want 0", issue_op); end

        set_disp(OP_ADD, 32'd4, 32'd5, 1'b0, 4'd0, 1'b0, 4'd0, 4'd6);
        tick();
        set_disp(OP_SUB, 32'd9, 32'd3, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (issue_op !== 6'd0 || rs_full !== 1'b0) begin
                n_fail++; $display("FAIL stall_%0d: got op=%0h full=%0b want 0 0", i, issue_op, rs_full); end
        end
        rdy_in = 1'b1;
        tick();
        n_checks++; if (issue_op !== OP_ADD || issue_rs1 !== 32'd4 || issue_rs2 !== 32'd5 || issue_robid !== 4'd6) begin
            n_fail++; $display("FAIL stall_release_a: got %0h %0h %0h %0h want 1 4 5 6", issue_op, issue_rs1, issue_rs2, issue_robid); end
        set_idle();
        tick();
        n_checks++; if (issue_op !== OP_SUB || issue_rs1 !== 32'd9 || issue_rs2 !== 32'd3 || issue_robid !== 4'd7) begin
            n_fail++; $display("FAIL stall_release_b: got %0h %0h %0h %0h want 2 9 3 7", issue_op, issue_rs1, issue_rs2, issue_robid); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            rdy_in         = ($urandom_range(0, 9) != 0);
            clear_in       = ($urandom_range(0, 59) == 0);
            disp_valid     = ($urandom_range(0, 2) != 0);
            disp_op        = 6'($urandom_range(1, 63));
            disp_vj        = $urandom;
            disp_vk        = $urandom;
            disp_qj_busy   = ($urandom_range(0, 1) == 1);
            disp_qk_busy   = ($urandom_range(0, 1) == 1);
            disp_qj        = 4'($urandom_range(0, 15));
            disp_qk        = 4'($urandom_range(0, 15));
            disp_robid     = 4'($urandom_range(0, 15));
            cdb_alu_valid  = ($urandom_range(0, 1) == 1);
            cdb_alu_robid  = 4'($urandom_range(0, 15));
            cdb_alu_result = $urandom;
            cdb_lsb_valid  = ($urandom_range(0, 1) == 1);
            cdb_lsb_robid  = 4'($urandom_range(0, 15));
            cdb_lsb_result = $urandom;
            tick();
            n_checks++; if (issue_op !== m_op) begin
                n_fail++; $display("FAIL rand_op c=%0d: got %0h want %0h", c, issue_op, m_op); end
            n_checks++; if (issue_rs1 !== m_rs1 || issue_rs2 !== m_rs2 || issue_robid !== m_robid) begin
                n_fail++; $display("FAIL rand_operands c=%0d: got %0h %0h %0h want %0h %0h %0h",
                                   c, issue_rs1, issue_rs2, issue_robid, m_rs1, m_rs2, m_robid); end
            n_checks++; if (rs_full !== m_full) begin
                n_fail++; $display("FAIL rand_full c=%0d: got %0b want %0b", c, rs_full, m_full); end
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_lsb_wakeup();
        test_bypass();
        test_fill_full();
        test_clear_rdy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_rs_scheduler.md
Name: alu_rs_scheduler

Overview:
- Reservation station and issue scheduler in front of the single shared ALU in the out-of-order core.
- Holds dispatched ALU/branch micro-ops until both operands are ready, snoops the two CDB broadcast buses (ALU and load/store) for operand wakeup, and issues one ready entry per cycle.
- Issue outputs drive the ALU's rs1/rs2/op/robid inputs directly. Op 0 means the ALU is idle.

Parameters:
- RS_SIZE, 8, number of entries (power of two, 2..16)
- ROB_W, 4, RoB index width (matches the global RoB_addr)
- OP_W, 6, internal opcode width; op 0 is reserved as "no operation"

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset, asynchronous, active-high
- rdy_in  in  1  global enable; when low, all state holds
- clear_in  in  1  flush on mispredict
- disp_valid  in  1  dispatch request
- disp_op  in  OP_W  opcode, nonzero
- disp_vj / disp_vk  in  32  operand values
- disp_qj_busy / disp_qk_busy  in  1  operand is pending on a RoB tag
- disp_qj / disp_qk  in  ROB_W  pending tags
- disp_robid  in  ROB_W  destination RoB index
- rs_full  out  1  all entries busy (registered)
- cdb_alu_valid, cdb_alu_robid[ROB_W], cdb_alu_result[32]  in  ALU broadcast
- cdb_lsb_valid, cdb_lsb_robid[ROB_W], cdb_lsb_result[32]  in  load/store broadcast
- issue_op  out  OP_W  to ALU op; 0 = idle
- issue_rs1 / issue_rs2  out  32  to ALU operands
- issue_robid  out  ROB_W  to ALU robid

Behaviour:
- Priority order: rst_in > clear_in > !rdy_in > normal operation.
- Reset (async): all entries not busy; rs_full=0; issue_op=0, issue_rs1=0, issue_rs2=0, issue_robid=0.
- Entry fields: busy, op, vj, vk, qj_busy, qk_busy, qj, qk, robid. An entry is ready when busy && !qj_busy && !qk_busy.
- Dispatch:
  - On a posedge with disp_valid and !rs_full, the request writes the lowest-index non-busy entry.
  - A dispatch arriving while rs_full=1 is ignored. Dispatch must not assert disp_valid while rs_full=1.
- Dispatch bypass: if a dispatched operand is pending and its tag matches a CDB bus valid in the same cycle, the entry stores the CDB value and clears the busy flag. If both buses match, ALU takes precedence.
- Wakeup: every cycle, every busy entry with qX_busy whose qX equals a valid CDB robid captures that result and clears qX_busy. Both operands may wake in the same cycle.
- Issue selection and timing:
  - The lowest-index entry that is ready at the start of the cycle is selected.
  - Its op, vj, vk and robid are registered onto the issue_* outputs at the posedge, and the entry is freed at the same edge.
  - Dispatch-to-issue latency: an entry with both operands ready issues at the edge after it is written. Total dispatch-to-ALU-result latency is 2 cycles.
  - Wakeup-to-issue: an entry woken at edge N issues at edge N+1 at the earliest.
- No ready entry: issue_op=0 at the next edge; the other issue_* outputs keep their previous values.
- Same-cycle issue and dispatch are allowed. A slot freed by issue is not reusable until the next cycle.
- rs_full is registered and equals "busy count after this edge == RS_SIZE". It updates in the same edge as the dispatch or issue that changes the count.
- clear_in (synchronous): all entries are invalidated, issue_op=0 at the next edge, and any same-cycle dispatch and wakeup are dropped. Takes effect even while rdy_in is low.
- rdy_in low: entries, flags and rs_full hold; issue_op is driven 0 at the next edge; CDB and dispatch are ignored. Upstream holds CDB and dispatch while rdy_in is low.
- Tags compare on the full ROB_W bits; no age ordering beyond index order.

Test Plan:
- Reset mid-run with 3 entries busy -> issue_op=0 and rs_full=0 immediately (asynchronous); after reset, the next ready dispatch issues from entry 0.
- Dispatch Add vj=5, vk=7, robid=3, no pending operands -> one edge later issue_op=Add, rs1=5, rs2=7, robid=3; the ALU result 12 appears the following cycle.
- Dispatch Sub with qj=2 pending and vk=1, then cdb_lsb robid=2 result=10 two cycles later -> issues on the next edge with rs1=10, rs2=1. A CDB for robid=6 causes no wakeup.
- Same-cycle bypass: dispatch with qk=4 pending while cdb_alu robid=4 result=0xFFFFFFFF -> the entry is ready and issues next edge with rs2=0xFFFFFFFF.
- Fill all 8 entries with qj=9 pending -> rs_full=1 and a 9th dispatch is ignored; broadcast robid=9 -> entries issue in index order 0..7 on 8 consecutive edges; rs_full drops after the first issue.
- 4 busy entries, assert clear_in together with disp_valid -> all entries cleared, the dispatch is dropped, issue_op=0; with rdy_in low for 3 cycles and ready entries present -> issue_op=0 and no entry is lost.
